div19x2: RTL and testbench



---
 rtl/div19x2.sv | 211 +++++++++++++++++++++
 tb/tb_div19x2.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div19x2.sv
// div19x2 -- dual-lane iterative divider (19-bit dividend / 9-bit divisor).
//
// Both lanes run in lock-step. They compute Q = N / D, truncated toward zero,
// and R = N - Q*D. R takes the sign of N.
//
// Ports:
//   CLK, RESET          clock, asynchronous active-low reset
//   IN_VALID/IN_READY   operand handshake; IN_READY is high only in IDLE
//   UNSIGNED            1 = unsigned, 0 = two's complement (latched on accept)
//   N1/D1, N2/D2        lane dividends (19b) and divisors (9b)
//   OUT_VALID/OUT_READY result handshake; results are held in HOLD
//   Q1/R1, Q2/R2        lane quotients (19b) and remainders (9b)
//   DIV0, OVF           per-lane divide-by-zero / signed-overflow (bit0 = lane 1)
//   ABORT               present only when DIV19X2_ABORT_EN is defined
//
// Parameters: BITS_PER_CYCLE (1 or 2), OVF_MODE ("SATURATE" or "WRAP").
module div19x2 #(
    parameter int    BITS_PER_CYCLE = 1,
    parameter string OVF_MODE       = "SATURATE"
) (
`ifdef DIV19X2_ABORT_EN
    input  logic        ABORT,
`endif
    input  logic        CLK,
    input  logic        RESET,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic        UNSIGNED,
    input  logic [18:0] N1,
    input  logic [8:0]  D1,
    input  logic [18:0] N2,
    input  logic [8:0]  D2,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [18:0] Q1,
    output logic [8:0]  R1,
    output logic [18:0] Q2,
    output logic [8:0]  R2,
    output logic [1:0]  DIV0,
    output logic [1:0]  OVF
);

    if (BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2) begin : g_bad_bpc
        $fatal(1, "div19x2: BITS_PER_CYCLE must be 1 or 2");
    end
    if (OVF_MODE != "SATURATE" && OVF_MODE != "WRAP") begin : g_bad_ovf
        $fatal(1, "div19x2: OVF_MODE must be SATURATE or WRAP");
    end

    localparam int         ITERS = (BITS_PER_CYCLE == 2) ? 10 : 19;
    localparam logic [4:0] LAST  = 5'(ITERS - 1);
    localparam bit         SAT   = (OVF_MODE == "SATURATE");

    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, HOLD} state_t;

    typedef struct packed {
        logic [19:0] num;   // dividend bits still to be consumed, MSB first
        logic [8:0]  rem;   // partial remainder magnitude
        logic [18:0] quo;   // quotient magnitude bits so far
    } step_t;

    state_t      r_state, w_next;
    logic [4:0]  r_cnt;
    logic        r_uns;
    logic [18:0] r_n1, r_n2;
    logic [8:0]  r_d1, r_d2;
    logic [19:0] r_num1, r_num2;
    logic [8:0]  r_den1, r_den2;
    logic [8:0]  r_rem1, r_rem2;
    logic [18:0] r_quo1, r_quo2;
    logic [18:0] r_q1, r_q2;
    logic [8:0]  r_r1, r_r2;
    logic [1:0]  r_div0, r_ovf;
    logic        w_abort;
    logic [18:0] w_mn1, w_mn2;
    logic [8:0]  w_md1, w_md2;
    step_t       w_s1, w_s2;
    logic [29:0] w_f1, w_f2;

`ifdef DIV19X2_ABORT_EN
    assign w_abort = ABORT;
`else
    assign w_abort = 1'b0;
`endif

    // One or two restoring steps on unsigned magnitudes.
    function automatic step_t div_step(step_t s, logic [8:0] den);
        step_t      o;
        logic [9:0] trial;
        o = s;
        for (int unsigned k = 0; k < BITS_PER_CYCLE; k++) begin
            trial = {o.rem, o.num[19]};
            o.num = {o.num[18:0], 1'b0};
            if (trial >= {1'b0, den}) begin
                o.rem = 9'(trial - {1'b0, den});
                o.quo = {o.quo[17:0], 1'b1};
            end else begin
                o.rem = trial[8:0];
                o.quo = {o.quo[17:0], 1'b0};
            end
        end
        return o;
    endfunction

    // Apply signs and special cases; returns {Q, R, div0, ovf}.
    function automatic logic [29:0] fix_lane(logic [18:0] n, logic [8:0] d, logic uns,
                                             logic [18:0] quo, logic [8:0] rem);
        logic        sn, sx, z, o;
        logic [18:0] q;
        logic [8:0]  r;
        sn = !uns && n[18];
        sx = sn ^ (!uns && d[8]);
        z  = (d == '0);
        o  = !uns && !z && (n == 19'h40000) && (d == 9'h1FF);
        if (z) begin
            q = '1;
            r = n[8:0];
        end else if (o) begin
            q = SAT ? 19'h3FFFF : 19'h40000;
            r = '0;
        end else begin
            q = sx ? 19'(-quo) : quo;
            r = sn ? 9'(-rem) : rem;
        end
        return {q, r, z, o};
    endfunction

    assign w_mn1 = (!r_uns && r_n1[18]) ? 19'(-r_n1) : r_n1;
    assign w_mn2 = (!r_uns && r_n2[18]) ? 19'(-r_n2) : r_n2;
    assign w_md1 = (!r_uns && r_d1[8])  ? 9'(-r_d1)  : r_d1;
    assign w_md2 = (!r_uns && r_d2[8])  ? 9'(-r_d2)  : r_d2;
    assign w_s1  = div_step({r_num1, r_rem1, r_quo1}, r_den1);
    assign w_s2  = div_step({r_num2, r_rem2, r_quo2}, r_den2);
    assign w_f1  = fix_lane(r_n1, r_d1, r_uns, r_quo1, r_rem1);
    assign w_f2  = fix_lane(r_n2, r_d2, r_uns, r_quo2, r_rem2);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (IN_VALID) w_next = PREP;
            PREP:    w_next = ITER;
            ITER:    if (r_cnt == LAST) w_next = FIX;
            FIX:     w_next = HOLD;
            HOLD:    if (OUT_READY) w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (w_abort && (r_state == PREP || r_state == ITER || r_state == FIX))
            w_next = IDLE;
    end

    always_comb begin
        IN_READY  = (r_state == IDLE);
        OUT_VALID = (r_state == HOLD);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_cnt  <= '0;
            r_uns  <= 1'b0;
            r_n1   <= '0;  r_n2   <= '0;
            r_d1   <= '0;  r_d2   <= '0;
            r_num1 <= '0;  r_num2 <= '0;
            r_den1 <= '0;  r_den2 <= '0;
            r_rem1 <= '0;  r_rem2 <= '0;
            r_quo1 <= '0;  r_quo2 <= '0;
            r_q1   <= '0;  r_q2   <= '0;
            r_r1   <= '0;  r_r2   <= '0;
            r_div0 <= '0;  r_ovf  <= '0;
        end else begin
            case (r_state)
                IDLE: if (IN_VALID) begin
                    r_uns <= UNSIGNED;
                    r_n1  <= N1;  r_d1 <= D1;
                    r_n2  <= N2;  r_d2 <= D2;
                end
                PREP: begin
                    // 2-bit mode consumes 20 bits, so pad a zero on top instead of below.
                    r_num1 <= (BITS_PER_CYCLE == 2) ? {1'b0, w_mn1} : {w_mn1, 1'b0};
                    r_num2 <= (BITS_PER_CYCLE == 2) ? {1'b0, w_mn2} : {w_mn2, 1'b0};
                    r_den1 <= w_md1;  r_den2 <= w_md2;
                    r_rem1 <= '0;     r_rem2 <= '0;
                    r_quo1 <= '0;     r_quo2 <= '0;
                    r_cnt  <= '0;
                end
                ITER: begin
                    r_cnt  <= r_cnt + 5'd1;
                    r_num1 <= w_s1.num;  r_rem1 <= w_s1.rem;  r_quo1 <= w_s1.quo;
                    r_num2 <= w_s2.num;  r_rem2 <= w_s2.rem;  r_quo2 <= w_s2.quo;
                end
                FIX: if (!w_abort) begin
                    {r_q1, r_r1, r_div0[0], r_ovf[0]} <= w_f1;
                    {r_q2, r_r2, r_div0[1], r_ovf[1]} <= w_f2;
                end
                default: ;
            endcase
        end
    end

    assign Q1   = r_q1;
    assign R1   = r_r1;
    assign Q2   = r_q2;
    assign R2   = r_r2;
    assign DIV0 = r_div0;
    assign OVF  = r_ovf;

endmodule

// File: tb/tb_div19x2.sv
// Testbench for div19x2. Instance A uses BITS_PER_CYCLE=1 and SATURATE.
// Instance B uses BITS_PER_CYCLE=2 and WRAP. Both share the operand bus.
module tb_div19x2;

    logic        CLK = 1'b0;
    logic        RESET, IN_VALID, UNSIGNED, OUT_READY;
    logic [18:0] N1, N2;
    logic [8:0]  D1, D2;
    logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
    logic [18:0] a_q1, a_q2, b_q1, b_q2;
    logic [8:0]  a_r1, a_r2, b_r1, b_r2;
    logic [1:0]  a_div0, a_ovf, b_div0, b_ovf;
`ifdef DIV19X2_ABORT_EN
    logic        abort_b;
`endif

    always #5 CLK = ~CLK;

    div19x2 #(.BITS_PER_CYCLE(1), .OVF_MODE("SATURATE")) u_dut_a (
`ifdef DIV19X2_ABORT_EN
        .ABORT(1'b0),
`endif
        .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(a_in_ready),
        .UNSIGNED(UNSIGNED), .N1(N1), .D1(D1), .N2(N2), .D2(D2),
        .OUT_VALID(a_out_valid), .OUT_READY(OUT_READY),
        .Q1(a_q1), .R1(a_r1), .Q2(a_q2), .R2(a_r2), .DIV0(a_div0), .OVF(a_ovf)
    );

    div19x2 #(.BITS_PER_CYCLE(2), .OVF_MODE("WRAP")) u_dut_b (
`ifdef DIV19X2_ABORT_EN
        .ABORT(abort_b),
`endif
        .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(b_in_ready),
        .UNSIGNED(UNSIGNED), .N1(N1), .D1(D1), .N2(N2), .D2(D2),
        .OUT_VALID(b_out_valid), .OUT_READY(OUT_READY),
        .Q1(b_q1), .R1(b_r1), .Q2(b_q2), .R2(b_r2), .DIV0(b_div0), .OVF(b_ovf)
    );

    typedef struct packed {
        logic [18:0] q1;
        logic [8:0]  r1;
        logic [18:0] q2;
        logic [8:0]  r2;
        logic [1:0]  div0;
        logic [1:0]  ovf;
    } res_t;

    res_t q_a[$];
    res_t q_b[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference lane built on integer / and %; returns {q, r, div0, ovf}.
    function automatic logic [29:0] lane_model(logic [18:0] n, logic [8:0] d, logic uns, logic sat);
        int          ni, di, qi, ri;
        logic [18:0] q;
        logic [8:0]  r;
        logic        z, o;
        z = 1'b0;
        o = 1'b0;
        if (d == 9'd0) begin
            q = 19'h7FFFF;
            r = n[8:0];
            z = 1'b1;
        end else begin
            if (uns) begin
                ni = int'({13'd0, n});
                di = int'({23'd0, d});
            end else begin
                ni = int'($signed(n));
                di = int'($signed(d));
            end
            qi = ni / di;
            ri = ni % di;
            if (!uns && qi > 262143) begin
                o = 1'b1;
                q = sat ? 19'h3FFFF : qi[18:0];
            end else begin
                q = qi[18:0];
            end
            r = ri[8:0];
        end
        return {q, r, z, o};
    endfunction

    function automatic res_t model(logic [18:0] n1, logic [8:0] d1, logic [18:0] n2,
                                   logic [8:0] d2, logic uns, logic sat);
        logic [29:0] l1, l2;
        res_t        e;
        l1 = lane_model(n1, d1, uns, sat);
        l2 = lane_model(n2, d2, uns, sat);
        e.q1   = l1[29:11];
        e.r1   = l1[10:2];
        e.q2   = l2[29:11];
        e.r2   = l2[10:2];
        e.div0 = {l2[1], l1[1]};
        e.ovf  = {l2[0], l1[0]};
        return e;
    endfunction

    task automatic compare_res(input string p, input logic [18:0] q1, input logic [8:0] r1,
                               input logic [18:0] q2, input logic [8:0] r2,
                               input logic [1:0] dz, input logic [1:0] ov, input res_t e);
        check({p, "_q1"}, q1, e.q1);
        check({p, "_r1"}, r1, e.r1);
        check({p, "_q2"}, q2, e.q2);
        check({p, "_r2"}, r2, e.r2);
        check({p, "_div0"}, dz, e.div0);
        check({p, "_ovf"}, ov, e.ovf);
    endtask

    // Results are compared on the handshake cycle.
    always @(negedge CLK) begin
        if (RESET && a_out_valid && OUT_READY) begin
            if (q_a.size() == 0) check("a_unexpected_valid", 1, 0);
            else compare_res("a", a_q1, a_r1, a_q2, a_r2, a_div0, a_ovf, q_a.pop_front());
        end
        if (RESET && b_out_valid && OUT_READY) begin
            if (q_b.size() == 0) check("b_unexpected_valid", 1, 0);
            else compare_res("b", b_q1, b_r1, b_q2, b_r2, b_div0, b_ovf, q_b.pop_front());
        end
    end

    task automatic send(input logic [18:0] n1, input logic [8:0] d1, input logic [18:0] n2,
                        input logic [8:0] d2, input logic uns, input logic push_b);
        int t = 0;
        while (!(a_in_ready && b_in_ready) && t < 60) begin
            @(posedge CLK); #1;
            t++;
        end
        if (t >= 60) check("send_ready_timeout", t, 0);
        N1 = n1; D1 = d1; N2 = n2; D2 = d2; UNSIGNED = uns;
        q_a.push_back(model(n1, d1, n2, d2, uns, 1'b1));
        if (push_b) q_b.push_back(model(n1, d1, n2, d2, uns, 1'b0));
        IN_VALID = 1'b1;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
    endtask

    // Cycles from the accept edge to the first OUT_VALID of each instance.
    task automatic watch(output int la, output int lb);
        la = -1;
        lb = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge CLK); #1;
            if (la < 0 && a_out_valid) la = c;
            if (lb < 0 && b_out_valid) lb = c;
            if (la >= 0 && lb >= 0) break;
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!(a_in_ready && b_in_ready) && t < 60) begin
            @(posedge CLK); #1;
            t++;
        end
        if (t >= 60) check("idle_timeout", t, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 500000");
        $fatal(1);
    end

    initial begin
        int   la, lb;
        logic seen;
        res_t e;
        RESET = 1'b0; IN_VALID = 1'b0; UNSIGNED = 1'b0; OUT_READY = 1'b1;
        N1 = '0; D1 = '0; N2 = '0; D2 = '0;
`ifdef DIV19X2_ABORT_EN
        abort_b = 1'b0;
`endif
        repeat (3) @(posedge CLK);
        #1;
        check("rst_in_ready_a", a_in_ready, 1);
        check("rst_in_ready_b", b_in_ready, 1);
        check("rst_out_valid_a", a_out_valid, 0);
        check("rst_q1_a", a_q1, 0);
        check("rst_flags_b", {b_div0, b_ovf}, 0);
        RESET = 1'b1;
        @(posedge CLK); #1;

        // Unsigned with latency checks for both BITS_PER_CYCLE settings.
        send(19'd1000, 9'd7, 19'd524287, 9'd511, 1'b1, 1'b1);
        watch(la, lb);
        check("latency_bpc1", la, 21);
        check("latency_bpc2", lb, 12);
        wait_idle();

`ifdef DIV19X2_ABORT_EN
        // Abort B during ITER. A runs the same operation to completion.
        send(19'd500, 9'd3, 19'd100, 9'd9, 1'b1, 1'b0);
        repeat (3) begin @(posedge CLK); #1; end
        abort_b = 1'b1;
        @(posedge CLK); #1;
        abort_b = 1'b0;
        check("abort_idle_b", b_in_ready, 1);
        check("abort_q1_kept_b", b_q1, 142);
        wait_idle();
`endif

        // Signed operands.
        send(-19'd100, 9'd7, 19'd100, -9'd7, 1'b0, 1'b1);
        watch(la, lb);
        wait_idle();

        // Divide by zero on lane 2 only.
        send(19'd50, 9'd5, 19'h12345, 9'd0, 1'b0, 1'b1);
        watch(la, lb);
        wait_idle();

        // Signed overflow on both lanes.
        send(19'h40000, 9'h1FF, 19'h40000, 9'h1FF, 1'b0, 1'b1);
        watch(la, lb);
        wait_idle();

        // Back-pressure: results must hold and IN_READY must stay low.
        OUT_READY = 1'b0;
        send(19'd300, 9'd17, 19'd77777, 9'd255, 1'b1, 1'b1);
        watch(la, lb);
        check("bp_latency_a", la, 21);
        e = q_a[0];
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            check("bp_valid_a", a_out_valid, 1);
            check("bp_in_ready_a", a_in_ready, 0);
            check("bp_in_ready_b", b_in_ready, 0);
            check("bp_q1_a", a_q1, e.q1);
            check("bp_r2_a", a_r2, e.r2);
        end
        OUT_READY = 1'b1;
        wait_idle();

        // Reset mid-ITER: the in-flight result is discarded.
        send(19'd1000, 9'd7, 19'd524287, 9'd511, 1'b1, 1'b1);
        repeat (5) begin @(posedge CLK); #1; end
        RESET = 1'b0;
        #1;
        check("midrst_in_ready_a", a_in_ready, 1);
        check("midrst_in_ready_b", b_in_ready, 1);
        check("midrst_q1_a", a_q1, 0);
        q_a.delete();
        q_b.delete();
        #2 RESET = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(posedge CLK); #1;
            if (a_out_valid || b_out_valid) seen = 1'b1;
        end
        check("midrst_no_valid", seen, 0);
        send(19'd50, 9'd5, 19'd100, -9'd7, 1'b0, 1'b1);
        watch(la, lb);
        check("post_rst_latency_a", la, 21);
        wait_idle();

        // Random operands in both modes.
        for (int i = 0; i < 6; i++) begin
            send(19'($urandom), 9'($urandom), 19'($urandom), 9'($urandom_range(0, 31)),
                 1'($urandom_range(0, 1)), 1'b1);
            watch(la, lb);
            wait_idle();
        end

        repeat (3) @(posedge CLK);
        #1;
        check("leftover_expected", q_a.size() + q_b.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
